// File: rtl/mask_row_sequencer.sv
// Coded-exposure mask row sequencer: streams WORDS_PER_ROW mask words per row,
// then presents the row address and pulses row_latch, for every row of every subframe.
module mask_row_sequencer #(
   parameter int NUM_ROWS      = 320,
   parameter int ROW_W         = 10,
   parameter int WORDS_PER_ROW = 20,
   parameter int LATCH_CYC     = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic [7:0]       cfg_num_subframes,
   input  logic [15:0]      mask_data,
   input  logic             mask_valid,
   output logic             mask_ready,
   output logic [16:1]      mSTREAM,
   output logic             mstream_en,
   output logic [ROW_W-1:0] ROWADD,
   output logic             row_latch,
   output logic             busy,
   output logic             done
);

   localparam int WORD_W = (WORDS_PER_ROW > 1) ? $clog2(WORDS_PER_ROW) : 1;
   localparam int LAT_W  = $clog2(LATCH_CYC + 1);

   typedef enum logic [1:0] {IDLE, LOAD, LATCH, DONE} state_t;

   state_t            state, next_state;
   logic [WORD_W-1:0] word_cnt;
   logic [ROW_W-1:0]  row_cnt;
   logic [7:0]        sub_cnt;
   logic [7:0]        cfg_q;
   logic [LAT_W-1:0]  lat_cnt;

   logic accept, word_last, row_last, sub_last, lat_last;
   logic mask_ready_d, row_latch_d, busy_d, done_d;

   // abort blocks the handshake even though mask_ready is still shown high that cycle
   assign accept    = mask_valid & mask_ready & ~abort;
   assign word_last = (word_cnt == WORD_W'(WORDS_PER_ROW - 1));
   assign row_last  = (row_cnt == ROW_W'(NUM_ROWS - 1));
   assign sub_last  = (sub_cnt == cfg_q - 8'd1);
   assign lat_last  = (lat_cnt == LAT_W'(LATCH_CYC));

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   // NOTE: every combinational output gets a default first, so no path infers a latch.
   always_comb begin
      next_state = state;
      if (abort) begin
         next_state = IDLE;
      end else begin
         unique case (state)
            IDLE:  if (start) next_state = LOAD;
            LOAD:  if (accept && word_last) next_state = LATCH;
            LATCH: if (lat_last) next_state = (row_last && sub_last) ? DONE : LOAD;
            DONE:  next_state = IDLE;
            default: next_state = IDLE;
         endcase
      end
   end

   // Outputs are decoded from the next state and registered below.
   always_comb begin
      mask_ready_d = (next_state == LOAD);
      busy_d       = (next_state != IDLE);
      done_d       = (next_state == DONE);
      // First LATCH cycle is address setup; high only while staying in LATCH.
      row_latch_d  = (state == LATCH) && (next_state == LATCH);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mask_ready <= 1'b0;
         mSTREAM    <= '0;
         mstream_en <= 1'b0;
         ROWADD     <= '0;
         row_latch  <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         word_cnt   <= '0;
         row_cnt    <= '0;
         sub_cnt    <= '0;
         cfg_q      <= '0;
         lat_cnt    <= '0;
      end else begin
         mask_ready <= mask_ready_d;
         mstream_en <= accept;
         row_latch  <= row_latch_d;
         busy       <= busy_d;
         done       <= done_d;
         lat_cnt    <= row_latch_d ? lat_cnt + LAT_W'(1) : '0;

         if (state == IDLE) begin
            word_cnt <= '0;
            row_cnt  <= '0;
            sub_cnt  <= '0;
            if (start && !abort)
               cfg_q <= (cfg_num_subframes == 8'd0) ? 8'd1 : cfg_num_subframes;
         end

         if (accept) begin
            mSTREAM  <= mask_data;
            word_cnt <= word_last ? '0 : word_cnt + WORD_W'(1);
            if (word_last) ROWADD <= row_cnt;
         end

         if (state == LATCH && lat_last && !abort) begin
            if (!row_last) begin
               row_cnt <= row_cnt + ROW_W'(1);
            end else if (!sub_last) begin
               sub_cnt <= sub_cnt + 8'd1;
               row_cnt <= '0;
            end
         end
      end
   end

endmodule

// File: tb/tb_mask_row_sequencer.sv
// Bench for mask_row_sequencer: vector table of whole sequences, randomized runs
// against a transaction-level model, and hand-written reset/abort/start corner cases.
module tb_mask_row_sequencer;

   localparam int NR      = 4;
   localparam int WPR     = 3;
   localparam int LC      = 2;
   localparam int ROW_CYC = WPR + LC + 1;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start, abort;
   logic [7:0]  cfg_num_subframes;
   logic [15:0] mask_data;
   logic        mask_valid;
   logic        mask_ready;
   logic [16:1] mSTREAM;
   logic        mstream_en;
   logic [1:0]  ROWADD;
   logic        row_latch, busy, done;

   int n_checks = 0;
   int n_err    = 0;

   mask_row_sequencer #(
      .NUM_ROWS(NR), .ROW_W(2), .WORDS_PER_ROW(WPR), .LATCH_CYC(LC)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .cfg_num_subframes(cfg_num_subframes), .mask_data(mask_data),
      .mask_valid(mask_valid), .mask_ready(mask_ready), .mSTREAM(mSTREAM),
      .mstream_en(mstream_en), .ROWADD(ROWADD), .row_latch(row_latch),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct {
      int cfg;
      int pct;
      bit incr;
      bit poke;
      int exp_words;
      int exp_latches;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Runs one full sequence and checks it against the expected word stream and row order.
   task automatic run(input int cfg, input int pct, input bit incr, input bit poke,
                      input int exp_words, input int exp_latches, input string name);
      int rows_q[$];
      int exp_rows[$];
      logic [15:0] acc_data;
      bit acc, prev_rl, got_done;
      int since_acc, lat_w, n_en, n_done, viol, last_rise, eff, idle_busy;
      since_acc = 99; lat_w = 0; n_en = 0; n_done = 0; viol = 0; last_rise = -1;
      prev_rl = 1'b0; got_done = 1'b0;
      cfg_num_subframes = 8'(cfg);
      mask_data = incr ? 16'h0001 : 16'($urandom);
      for (int cyc = 0; cyc < 3000 && !got_done; cyc++) begin
         mask_valid = (pct >= 100) || ($urandom_range(99) < pct);
         start      = (cyc == 0) || (poke && cyc == 7);
         acc        = mask_valid && mask_ready;
         acc_data   = mask_data;
         step();
         if (acc) begin
            check({name, "_stream"}, {15'd0, mstream_en, mSTREAM}, {15'd0, 1'b1, acc_data});
            n_en++;
            since_acc = 0;
            mask_data = incr ? mask_data + 16'd1 : 16'($urandom);
         end else begin
            if (mstream_en) viol++;
            since_acc++;
         end
         if (row_latch && mask_ready) viol++;
         if (row_latch && !prev_rl) begin
            rows_q.push_back(int'(ROWADD));
            if (since_acc != 1) viol++;
            if (pct >= 100 && last_rise >= 0 && cyc - last_rise != ROW_CYC) viol++;
            last_rise = cyc;
            lat_w = 1;
         end else if (row_latch) begin
            lat_w++;
         end else if (prev_rl && lat_w != LC) begin
            viol++;
         end
         if (done) begin
            n_done++;
            got_done = 1'b1;
            if (!prev_rl || row_latch) viol++;
         end
         prev_rl = row_latch;
      end
      start = 1'b0;
      mask_valid = 1'b0;
      check({name, "_done_seen"}, 32'(got_done), 32'd1);
      eff = (cfg == 0) ? 1 : cfg;
      for (int s = 0; s < eff; s++)
         for (int r = 0; r < NR; r++) exp_rows.push_back(r);
      check({name, "_words"}, n_en, exp_words);
      check({name, "_latches"}, rows_q.size(), exp_latches);
      for (int i = 0; i < exp_rows.size() && i < rows_q.size(); i++)
         check({name, "_rowadd"}, rows_q[i], exp_rows[i]);
      check({name, "_timing_violations"}, viol, 0);
      idle_busy = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (busy || done || mask_ready) idle_busy++;
      end
      check({name, "_done_count"}, n_done, 1);
      check({name, "_idle_after"}, idle_busy, 0);
   endtask

   vec_t vecs[5];

   initial begin
      int n_rise, hi_cnt, n_done, eff, cfg;
      bit hit;
      vecs[0] = '{cfg: 1, pct: 100, incr: 1'b1, poke: 1'b0, exp_words: 12, exp_latches: 4};
      vecs[1] = '{cfg: 1, pct: 50,  incr: 1'b1, poke: 1'b0, exp_words: 12, exp_latches: 4};
      vecs[2] = '{cfg: 2, pct: 100, incr: 1'b0, poke: 1'b0, exp_words: 24, exp_latches: 8};
      vecs[3] = '{cfg: 0, pct: 100, incr: 1'b0, poke: 1'b0, exp_words: 12, exp_latches: 4};
      vecs[4] = '{cfg: 1, pct: 70,  incr: 1'b0, poke: 1'b1, exp_words: 12, exp_latches: 4};

      rst_n = 1'b0; start = 1'b0; abort = 1'b0; cfg_num_subframes = 8'd1;
      mask_data = 16'h0; mask_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      check("reset_outputs", {1'b0, mask_ready, mSTREAM, mstream_en, ROWADD, row_latch, busy, done}, 32'd0);

      // Asynchronous reset in the middle of LOAD.
      start = 1'b1; mask_valid = 1'b1; mask_data = 16'hA5A5;
      step();
      start = 1'b0;
      step(); step();
      check("mid_load_active", {31'd0, busy}, 32'd1);
      #3 rst_n = 1'b0;
      #1;
      check("async_reset_outputs", {1'b0, mask_ready, mSTREAM, mstream_en, ROWADD, row_latch, busy, done}, 32'd0);
      mask_valid = 1'b0;
      step();
      rst_n = 1'b1;
      repeat (3) step();
      check("busy_after_reset", {31'd0, busy}, 32'd0);

      foreach (vecs[i])
         run(vecs[i].cfg, vecs[i].pct, vecs[i].incr, vecs[i].poke,
             vecs[i].exp_words, vecs[i].exp_latches, $sformatf("vec%0d", i));

      for (int k = 0; k < 3; k++) begin
         cfg = $urandom_range(0, 3);
         eff = (cfg == 0) ? 1 : cfg;
         run(cfg, $urandom_range(30, 100), 1'b0, 1'b0, eff * NR * WPR, eff * NR,
             $sformatf("rand%0d", k));
      end

      // Abort during the second high cycle of row 1's row_latch.
      cfg_num_subframes = 8'd1; mask_data = 16'h1234; mask_valid = 1'b1; start = 1'b1;
      n_rise = 0; hi_cnt = 0; hit = 1'b0;
      for (int cyc = 0; cyc < 200 && !hit; cyc++) begin
         step();
         start = 1'b0;
         if (row_latch) begin
            if (hi_cnt == 0) n_rise++;
            hi_cnt++;
         end else begin
            hi_cnt = 0;
         end
         if (n_rise == 2 && hi_cnt == 2) hit = 1'b1;
      end
      check("abort_point_reached", {31'd0, hit}, 32'd1);
      abort = 1'b1;
      step();
      abort = 1'b0;
      check("abort_outputs", {28'd0, row_latch, busy, mask_ready, mstream_en}, 32'd0);
      check("abort_rowadd_hold", {30'd0, ROWADD}, 32'd1);
      n_done = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (done || busy) n_done++;
      end
      mask_valid = 1'b0;
      check("abort_no_done", n_done, 0);
      run(1, 100, 1'b1, 1'b0, 12, 4, "after_abort");

      // start together with abort in IDLE is ignored.
      start = 1'b1; abort = 1'b1;
      step();
      start = 1'b0; abort = 1'b0;
      check("start_abort_idle", {30'd0, busy, mask_ready}, 32'd0);
      repeat (3) step();
      check("start_abort_still_idle", {31'd0, busy}, 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
